tomasulo_dispatch_unit: RTL and testbench

In-order dispatch stage that drives the Tomasulo back-end cluster's queue-side interface. It accepts one decoded instruction per cycle from the instruction queue. It resolves operands through an architectural register file and a register status table, allocates destination tags from a free list, and enables exactly one reservation queue. It snoops the CDB to forward results, retire values into the register file and recycle tags.

---
 rtl/tomasulo_pkg.sv | 56 +++++
 rtl/tomasulo_dispatch_unit_tag_free_list.sv | 45 ++++
 rtl/tomasulo_dispatch_unit.sv | 143 ++++++++++++++
 tb/tb_tomasulo_dispatch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths, unit encoding and payload types for the Tomasulo dispatch slice.
package tomasulo_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned NUM_TAGS = 2 ** TAG_W;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_W    = $clog2(NUM_REGS);
    localparam int unsigned COUNT_W  = TAG_W + 1;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_AGU = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } reg_status_t;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             valid;
    } operand_t;

    // Read a source operand from pre-update state, forwarding a matching CDB result.
    function automatic operand_t resolve_operand(
        input logic             used,
        input logic             is_x0,
        input reg_status_t      st,
        input logic [XLEN-1:0]  rf_data,
        input logic             cdb_valid,
        input logic [TAG_W-1:0] cdb_tag,
        input logic [XLEN-1:0]  cdb_data
    );
        operand_t op;
        op.data  = '0;
        op.tag   = '0;
        op.valid = 1'b1;
        if (used && !is_x0) begin
            if (!st.busy) begin
                op.data = rf_data;
            end else if (cdb_valid && (cdb_tag == st.tag)) begin
                op.data = cdb_data;
            end else begin
                op.valid = 1'b0;
                op.tag   = st.tag;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/tomasulo_dispatch_unit_tag_free_list.sv
// Circular FIFO of free destination tags; reset fills it with every tag in order.
module tag_free_list
    import tomasulo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [TAG_W-1:0]   push_tag,
    input  logic               pop,
    output logic [TAG_W-1:0]   head,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [TAG_W-1:0] head_ptr;
    logic [TAG_W-1:0] tail_ptr;
    logic             do_pop;

    assign head   = mem[head_ptr];
    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                mem[i] <= TAG_W'(i);
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= COUNT_W'(NUM_TAGS);
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_tag;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + COUNT_W'(push) - COUNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/tomasulo_dispatch_unit.sv
// In-order dispatch: renames through the status table, allocates tags, steers to one queue.
module tomasulo_dispatch_unit
    import tomasulo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               iq_valid,
    output logic               iq_ready,
    input  logic [1:0]         iq_unit,
    input  logic [REG_W-1:0]   iq_rs1,
    input  logic [REG_W-1:0]   iq_rs2,
    input  logic [REG_W-1:0]   iq_rd,
    input  logic               iq_rs1_used,
    input  logic               iq_rs2_used,
    input  logic               iq_rd_used,
    input  logic               iq_op2_imm,
    input  logic [XLEN-1:0]    iq_imm,
    input  logic [2:0]         iq_funct3,
    input  logic [2:0]         iq_alu_ext,
    input  logic               iq_agu_ls,
    output logic [XLEN-1:0]    queue_op1_data,
    output logic [XLEN-1:0]    queue_op2_data,
    output logic [TAG_W-1:0]   queue_op1_tag,
    output logic [TAG_W-1:0]   queue_op2_tag,
    output logic               queue_op1_data_valid,
    output logic               queue_op2_data_valid,
    output logic [TAG_W-1:0]   queue_rd_tag,
    output logic               queue_rd_tag_valid,
    output logic [2:0]         queue_funct3,
    output logic [2:0]         queue_alu_ext,
    output logic               queue_agu_ls,
    output logic [XLEN-1:0]    queue_agu_imm,
    output logic               queue_alu_en,
    output logic               queue_agu_en,
    output logic               queue_mul_en,
    output logic               queue_div_en,
    input  logic               queue_alu_full,
    input  logic               queue_agu_full,
    input  logic               queue_mul_full,
    input  logic               queue_div_full,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [XLEN-1:0]    cdb_data
);

    logic [XLEN-1:0] regs   [NUM_REGS];
    reg_status_t     status [NUM_REGS];

    logic [TAG_W-1:0]   fl_head;
    logic               fl_empty;
    logic [COUNT_W-1:0] fl_count;

    logic     unit_full;
    logic     need_tag;
    logic     accept;
    logic     alloc;
    operand_t op1;
    operand_t op2;

    tag_free_list u_free_list (
        .clk      (clk),
        .rst      (rst),
        .push     (cdb_valid),
        .push_tag (cdb_tag),
        .pop      (alloc),
        .head     (fl_head),
        .empty    (fl_empty),
        .count    (fl_count)
    );

    // Acceptance: target queue has room and, if a destination is written, a tag is free.
    always_comb begin
        unit_full = 1'b0;
        case (unit_e'(iq_unit))
            UNIT_ALU: unit_full = queue_alu_full;
            UNIT_AGU: unit_full = queue_agu_full;
            UNIT_MUL: unit_full = queue_mul_full;
            UNIT_DIV: unit_full = queue_div_full;
            default:  unit_full = 1'b1;
        endcase
        need_tag = iq_rd_used & (iq_rd != '0);
        accept   = rst & iq_valid & ~unit_full & (~need_tag | ~fl_empty);
        alloc    = accept & need_tag;
    end

    // Operand and payload steering toward the queues.
    always_comb begin
        op1 = resolve_operand(iq_rs1_used, iq_rs1 == '0, status[iq_rs1], regs[iq_rs1],
                              cdb_valid, cdb_tag, cdb_data);
        op2 = resolve_operand(iq_rs2_used, iq_rs2 == '0, status[iq_rs2], regs[iq_rs2],
                              cdb_valid, cdb_tag, cdb_data);
        if (iq_op2_imm && (unit_e'(iq_unit) == UNIT_ALU)) begin
            op2.data  = iq_imm;
            op2.tag   = '0;
            op2.valid = 1'b1;
        end

        iq_ready             = accept;
        queue_op1_data       = op1.data;
        queue_op1_tag        = op1.tag;
        queue_op1_data_valid = op1.valid;
        queue_op2_data       = op2.data;
        queue_op2_tag        = op2.tag;
        queue_op2_data_valid = op2.valid;
        queue_rd_tag         = need_tag ? fl_head : '0;
        queue_rd_tag_valid   = need_tag;
        queue_funct3         = iq_funct3;
        queue_alu_ext        = iq_alu_ext;
        queue_agu_ls         = iq_agu_ls;
        queue_agu_imm        = iq_imm;
        queue_alu_en         = accept & (unit_e'(iq_unit) == UNIT_ALU);
        queue_agu_en         = accept & (unit_e'(iq_unit) == UNIT_AGU);
        queue_mul_en         = accept & (unit_e'(iq_unit) == UNIT_MUL);
        queue_div_en         = accept & (unit_e'(iq_unit) == UNIT_DIV);
    end

    // Retire CDB results; a same-cycle re-tag wins the status entry but the value still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r]   <= '0;
                status[r] <= '0;
            end
        end else begin
            if (cdb_valid) begin
                for (int unsigned r = 1; r < NUM_REGS; r++) begin
                    if (status[r].busy && (status[r].tag == cdb_tag)) begin
                        regs[r]        <= cdb_data;
                        status[r].busy <= 1'b0;
                    end
                end
            end
            if (alloc) begin
                status[iq_rd] <= '{busy: 1'b1, tag: fl_head};
            end
        end
    end

    // Only allocated tags are ever broadcast, so a full free list never sees a push.
    assert property (@(posedge clk) disable iff (!rst)
        !(cdb_valid && (fl_count == COUNT_W'(NUM_TAGS))));

endmodule

// File: tb/tb_tomasulo_dispatch_unit.sv
// Directed bench for tomasulo_dispatch_unit with hand-computed expectations.
module tb_tomasulo_dispatch_unit;
    import tomasulo_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              iq_valid, iq_ready;
    logic [1:0]        iq_unit;
    logic [4:0]        iq_rs1, iq_rs2, iq_rd;
    logic              iq_rs1_used, iq_rs2_used, iq_rd_used, iq_op2_imm;
    logic [31:0]       iq_imm;
    logic [2:0]        iq_funct3, iq_alu_ext;
    logic              iq_agu_ls;
    logic [31:0]       queue_op1_data, queue_op2_data, queue_agu_imm;
    logic [5:0]        queue_op1_tag, queue_op2_tag, queue_rd_tag;
    logic              queue_op1_data_valid, queue_op2_data_valid, queue_rd_tag_valid;
    logic [2:0]        queue_funct3, queue_alu_ext;
    logic              queue_agu_ls;
    logic              queue_alu_en, queue_agu_en, queue_mul_en, queue_div_en;
    logic              queue_alu_full, queue_agu_full, queue_mul_full, queue_div_full;
    logic              cdb_valid;
    logic [5:0]        cdb_tag;
    logic [31:0]       cdb_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tomasulo_dispatch_unit dut (
        .clk(clk), .rst(rst),
        .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_unit(iq_unit),
        .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_rd(iq_rd),
        .iq_rs1_used(iq_rs1_used), .iq_rs2_used(iq_rs2_used), .iq_rd_used(iq_rd_used),
        .iq_op2_imm(iq_op2_imm), .iq_imm(iq_imm),
        .iq_funct3(iq_funct3), .iq_alu_ext(iq_alu_ext), .iq_agu_ls(iq_agu_ls),
        .queue_op1_data(queue_op1_data), .queue_op2_data(queue_op2_data),
        .queue_op1_tag(queue_op1_tag), .queue_op2_tag(queue_op2_tag),
        .queue_op1_data_valid(queue_op1_data_valid), .queue_op2_data_valid(queue_op2_data_valid),
        .queue_rd_tag(queue_rd_tag), .queue_rd_tag_valid(queue_rd_tag_valid),
        .queue_funct3(queue_funct3), .queue_alu_ext(queue_alu_ext),
        .queue_agu_ls(queue_agu_ls), .queue_agu_imm(queue_agu_imm),
        .queue_alu_en(queue_alu_en), .queue_agu_en(queue_agu_en),
        .queue_mul_en(queue_mul_en), .queue_div_en(queue_div_en),
        .queue_alu_full(queue_alu_full), .queue_agu_full(queue_agu_full),
        .queue_mul_full(queue_mul_full), .queue_div_full(queue_div_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] unit, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic ud, input logic imm_sel, input logic [31:0] imm);
        iq_valid    = 1'b1;
        iq_unit     = unit;
        iq_rs1      = rs1;
        iq_rs1_used = u1;
        iq_rs2      = rs2;
        iq_rs2_used = u2;
        iq_rd       = rd;
        iq_rd_used  = ud;
        iq_op2_imm  = imm_sel;
        iq_imm      = imm;
    endtask

    initial begin
        rst = 1'b0;
        iq_valid = 1'b0; iq_unit = 2'd0; iq_rs1 = '0; iq_rs2 = '0; iq_rd = '0;
        iq_rs1_used = 1'b0; iq_rs2_used = 1'b0; iq_rd_used = 1'b0; iq_op2_imm = 1'b0;
        iq_imm = '0; iq_funct3 = '0; iq_alu_ext = '0; iq_agu_ls = 1'b0;
        queue_alu_full = 1'b0; queue_agu_full = 1'b0; queue_mul_full = 1'b0; queue_div_full = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

        // Held in reset with a valid instruction: nothing may dispatch.
        drive(UNIT_ALU, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 32'h0);
        #3;
        chk("rst_ready", 32'(iq_ready), 32'd0);
        chk("rst_alu_en", 32'(queue_alu_en), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // add x1 = x2 + x3 right after reset
        iq_funct3 = 3'd5; iq_alu_ext = 3'd2;
        #1;
        chk("t1_ready", 32'(iq_ready), 32'd1);
        chk("t1_alu_en", 32'(queue_alu_en), 32'd1);
        chk("t1_agu_en", 32'(queue_agu_en), 32'd0);
        chk("t1_op1", queue_op1_data, 32'd0);
        chk("t1_op1_v", 32'(queue_op1_data_valid), 32'd1);
        chk("t1_op2_v", 32'(queue_op2_data_valid), 32'd1);
        chk("t1_rd_tag", 32'(queue_rd_tag), 32'd0);
        chk("t1_rd_v", 32'(queue_rd_tag_valid), 32'd1);
        chk("t1_funct3", 32'(queue_funct3), 32'd5);
        chk("t1_alu_ext", 32'(queue_alu_ext), 32'd2);
        @(negedge clk);

        // x5 producer gets tag 1
        drive(UNIT_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0);
        #1;
        chk("t2_rd_tag", 32'(queue_rd_tag), 32'd1);
        @(negedge clk);

        // consumer of x5 and x1, writes x6 with tag 2
        drive(UNIT_ALU, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h0);
        #1;
        chk("t3_op1_v", 32'(queue_op1_data_valid), 32'd0);
        chk("t3_op1_tag", 32'(queue_op1_tag), 32'd1);
        chk("t3_op2_v", 32'(queue_op2_data_valid), 32'd0);
        chk("t3_op2_tag", 32'(queue_op2_tag), 32'd0);
        chk("t3_rd_tag", 32'(queue_rd_tag), 32'd2);
        @(negedge clk);

        // broadcast tag 1 with no instruction
        iq_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_data = 32'hDEADBEEF;
        #1;
        chk("t4_idle_ready", 32'(iq_ready), 32'd0);
        @(negedge clk);
        cdb_valid = 1'b0;

        // x5 now from regfile; op2 from immediate
        drive(UNIT_ALU, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0000_0ABC);
        #1;
        chk("t5_op1", queue_op1_data, 32'hDEADBEEF);
        chk("t5_op1_v", 32'(queue_op1_data_valid), 32'd1);
        chk("t5_op2_imm", queue_op2_data, 32'h0000_0ABC);
        chk("t5_op2_v", 32'(queue_op2_data_valid), 32'd1);
        chk("t5_rd_v", 32'(queue_rd_tag_valid), 32'd0);
        @(negedge clk);

        // same-cycle forward of x6 (tag 2) to a DIV
        drive(UNIT_DIV, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h1234_5678;
        #1;
        chk("t6_fwd", queue_op1_data, 32'h1234_5678);
        chk("t6_fwd_v", 32'(queue_op1_data_valid), 32'd1);
        chk("t6_div_en", 32'(queue_div_en), 32'd1);
        chk("t6_alu_en", 32'(queue_alu_en), 32'd0);
        @(negedge clk);
        cdb_valid = 1'b0;

        // x4 producer gets tag 3
        drive(UNIT_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0);
        #1;
        chk("t7_rd_tag", 32'(queue_rd_tag), 32'd3);
        @(negedge clk);

        // retag x4 while tag 3 retires; x6 read back from regfile
        drive(UNIT_ALU, 5'd6, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0);
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h44;
        #1;
        chk("t8_rd_tag", 32'(queue_rd_tag), 32'd4);
        chk("t8_x6", queue_op1_data, 32'h1234_5678);
        @(negedge clk);
        cdb_valid = 1'b0;

        drive(UNIT_ALU, 5'd4, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("t9_x4_v", 32'(queue_op1_data_valid), 32'd0);
        chk("t9_x4_tag", 32'(queue_op1_tag), 32'd4);
        chk("t9_x5", queue_op2_data, 32'hDEADBEEF);
        @(negedge clk);

        // MUL queue full: stall without consuming a tag
        drive(UNIT_MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0);
        queue_mul_full = 1'b1;
        #1;
        chk("t10_ready", 32'(iq_ready), 32'd0);
        chk("t10_mul_en", 32'(queue_mul_en), 32'd0);
        chk("t10_alu_en", 32'(queue_alu_en), 32'd0);
        @(negedge clk);
        queue_mul_full = 1'b0;
        #1;
        chk("t11_ready", 32'(iq_ready), 32'd1);
        chk("t11_mul_en", 32'(queue_mul_en), 32'd1);
        chk("t11_rd_tag", 32'(queue_rd_tag), 32'd5);
        @(negedge clk);

        // mid-operation reset drops all in-flight tags
        drive(UNIT_ALU, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_ready", 32'(iq_ready), 32'd0);
        chk("mrst_alu_en", 32'(queue_alu_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_x4_v", 32'(queue_op1_data_valid), 32'd1);
        chk("mrst_x4", queue_op1_data, 32'd0);
        @(negedge clk);

        // drain the whole free list
        for (int i = 0; i < 64; i++) begin
            drive(UNIT_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'(1 + i % 31), 1'b1, 1'b0, 32'h0);
            #1;
            chk("drain_ready", 32'(iq_ready), 32'd1);
            chk("drain_tag", 32'(queue_rd_tag), 32'(i));
            @(negedge clk);
        end

        drive(UNIT_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0);
        #1;
        chk("empty_ready", 32'(iq_ready), 32'd0);
        chk("empty_alu_en", 32'(queue_alu_en), 32'd0);

        // store needs no tag; op2 immediate ignored outside ALU
        drive(UNIT_AGU, 5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 32'h10);
        iq_agu_ls = 1'b1;
        #1;
        chk("st_ready", 32'(iq_ready), 32'd1);
        chk("st_agu_en", 32'(queue_agu_en), 32'd1);
        chk("st_alu_en", 32'(queue_alu_en), 32'd0);
        chk("st_rd_v", 32'(queue_rd_tag_valid), 32'd0);
        chk("st_op1_v", 32'(queue_op1_data_valid), 32'd1);
        chk("st_op2_v", 32'(queue_op2_data_valid), 32'd0);
        chk("st_op2_tag", 32'(queue_op2_tag), 32'd63);
        chk("st_agu_imm", queue_agu_imm, 32'h10);
        chk("st_agu_ls", 32'(queue_agu_ls), 32'd1);
        @(negedge clk);
        iq_agu_ls = 1'b0;

        // tag 7 returns: not allocatable until the following cycle
        drive(UNIT_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0);
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h77;
        #1;
        chk("push_same_ready", 32'(iq_ready), 32'd0);
        @(negedge clk);
        cdb_valid = 1'b0;
        #1;
        chk("push_next_ready", 32'(iq_ready), 32'd1);
        chk("push_next_tag", 32'(queue_rd_tag), 32'd7);
        chk("push_next_alu_en", 32'(queue_alu_en), 32'd1);
        @(negedge clk);
        iq_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
